// File: rtl/rv32i_regdump.sv
// Debug read-out engine: walks x0..x(NREGS-1) through a spare regfile read
// port and streams each register as an {index, data} beat on valid/ready.
module rv32i_regdump #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  RdRA,
    input  logic [31:0] RdRD,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data
);

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] ptr;
    logic       handshake;
    logic       last_beat;

    assign handshake = (state == SEND) && out_ready;
    assign last_beat = (out_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SEND;
            SEND: if (handshake && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SEND);
        out_valid = (state == SEND);
        RdRA      = ptr;
    end

    // ptr runs one register ahead of out_idx so the next beat can be loaded
    // on the same edge that retires the current one; it parks at the last
    // index instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            out_idx  <= '0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        out_data <= RdRD;
                        out_idx  <= '0;
                        ptr      <= 5'd1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (!last_beat) begin
                            out_data <= RdRD;
                            out_idx  <= ptr;
                            if (ptr != LAST_IDX) begin
                                ptr <= ptr + 5'd1;
                            end
                        end else begin
                            ptr  <= '0;
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_regdump.sv
// Scoreboard bench for rv32i_regdump: a 32-register and a 4-register instance
// share one regfile model; expected beats are snapshotted when a dump starts.
module tb_rv32i_regdump;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_v   [2];
    logic        ready_v   [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        valid_v   [2];
    logic [4:0]  ra_v      [2];
    logic [4:0]  idx_v     [2];
    logic [31:0] rd_v      [2];
    logic [31:0] data_v    [2];
    logic [31:0] regs      [32];

    beat_t q0[$];
    beat_t q1[$];
    int    rmode    [2];
    bit    m_active [2];
    bit    m_done   [2];
    beat_t mon_b;
    beat_t upd_b;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    assign rd_v[0] = regs[ra_v[0]];
    assign rd_v[1] = regs[ra_v[1]];

    rv32i_regdump #(.NREGS(32)) dut32 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .RdRA(ra_v[0]), .RdRD(rd_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
        .out_idx(idx_v[0]), .out_data(data_v[0])
    );

    rv32i_regdump #(.NREGS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .RdRA(ra_v[1]), .RdRD(rd_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
        .out_idx(idx_v[1]), .out_data(data_v[1])
    );

    function automatic int nr(input int d);
        return (d == 0) ? 32 : 4;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t q_front(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int d, output beat_t b);
        if (d == 0) b = q0.pop_front();
        else        b = q1.pop_front();
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Expected beats: every register as it reads when the dump is requested.
    task automatic push_dump(input int d);
        beat_t b;
        for (int k = 0; k < nr(d); k++) begin
            b.idx  = 5'(k);
            b.data = (k == 0) ? 32'h0 : regs[k];
            if (d == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1 start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done_v[d]) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout dut%0d: got no done after %0d cycles, required done", d, budget);
    endtask

    // Monitor: compares DUT outputs against the reference state mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 1'b0;
                m_done[d]   = 1'b0;
                chk("rst_valid", d, 32'(valid_v[d]), 32'h0);
                chk("rst_busy",  d, 32'(busy_v[d]),  32'h0);
                chk("rst_done",  d, 32'(done_v[d]),  32'h0);
                chk("rst_idx",   d, 32'(idx_v[d]),   32'h0);
                chk("rst_data",  d, data_v[d],       32'h0);
                chk("rst_ra",    d, 32'(ra_v[d]),    32'h0);
            end else begin
                chk("valid", d, 32'(valid_v[d]), 32'(m_active[d]));
                chk("busy",  d, 32'(busy_v[d]),  32'(m_active[d]));
                chk("done",  d, 32'(done_v[d]),  32'(m_done[d]));
                if (m_active[d]) begin
                    if (q_size(d) == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_beat dut%0d: got beat idx %0d, required none", d, idx_v[d]);
                    end else begin
                        mon_b = q_front(d);
                        chk("beat_idx",  d, 32'(idx_v[d]), 32'(mon_b.idx));
                        chk("beat_data", d, data_v[d],     mon_b.data);
                    end
                end else begin
                    chk("idle_ra", d, 32'(ra_v[d]), 32'h0);
                end
            end
        end
    end

    // Reference state update on the clock edge, using the inputs the DUT samples.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 1'b0;
                m_done[d]   = 1'b0;
            end else begin
                m_done[d] = 1'b0;
                if (m_active[d]) begin
                    if (ready_v[d] && q_size(d) > 0) begin
                        q_pop(d, upd_b);
                        if (int'(upd_b.idx) == nr(d) - 1) begin
                            m_active[d] = 1'b0;
                            m_done[d]   = 1'b1;
                        end
                    end
                end else if (start_v[d]) begin
                    m_active[d] = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                ready_v[d] = (rmode[d] != 0) ? 1'($urandom % 2) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            ready_v[d] = 1'b1;
            rmode[d]   = 0;
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
        end
        for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // basic dump, ready held high
        push_dump(0);
        pulse_start(0);
        wait_done(0, 100, n);
        chk("done_cycle", 0, 32'(n), 32'd33);
        chk("q_drained", 0, 32'(q_size(0)), 32'h0);
        @(posedge clk); #1;

        // random backpressure with fresh random register contents
        for (int k = 1; k < 32; k++) regs[k] = $urandom;
        rmode[0] = 1;
        push_dump(0);
        pulse_start(0);
        wait_done(0, 1000, n);
        chk("q_drained", 0, 32'(q_size(0)), 32'h0);
        rmode[0] = 0;
        @(posedge clk); #1;

        // start pulses while busy are ignored
        push_dump(0);
        pulse_start(0);
        repeat (5) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        wait_done(0, 100, n);
        chk("q_drained", 0, 32'(q_size(0)), 32'h0);
        repeat (5) @(posedge clk);
        #1;

        // x7 written after its beat is loaded: old value now, new value next dump
        regs[7] = 32'h1234_5678;
        push_dump(0);
        pulse_start(0);
        n = 0;
        while (!(valid_v[0] && idx_v[0] == 5'd7) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 regs[7] = 32'hDEAD_BEEF;
        wait_done(0, 100, n);
        @(posedge clk); #1;
        push_dump(0);
        pulse_start(0);
        wait_done(0, 100, n);
        chk("q_drained", 0, 32'(q_size(0)), 32'h0);
        @(posedge clk); #1;

        // reset after idx 10 is accepted, then a full fresh dump
        push_dump(0);
        pulse_start(0);
        n = 0;
        while (!(valid_v[0] && ready_v[0] && idx_v[0] == 5'd10) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        q0.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push_dump(0);
        pulse_start(0);
        wait_done(0, 100, n);
        chk("done_cycle", 0, 32'(n), 32'd33);
        @(posedge clk); #1;

        // NREGS=4, back-to-back: second start issued in the done cycle
        push_dump(1);
        pulse_start(1);
        wait_done(1, 20, n);
        chk("done_cycle", 1, 32'(n), 32'd5);
        regs[2] = 32'hCAFE_0002;
        push_dump(1);
        start_v[1] = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
        wait_done(1, 20, n);
        chk("done_cycle", 1, 32'(n), 32'd5);
        chk("q_drained", 1, 32'(q_size(1)), 32'h0);

        // NREGS=4 under backpressure
        rmode[1] = 1;
        @(posedge clk); #1;
        push_dump(1);
        pulse_start(1);
        wait_done(1, 200, n);
        chk("q_drained", 1, 32'(q_size(1)), 32'h0);
        rmode[1] = 0;
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
